// File: rtl/sync_fifo_reg_ext.sv
// ---------------------------------------------------------------------------
// sync_fifo_reg_ext
//   Register-based single-clock FIFO for buffering between bus-side logic and
//   local datapaths. It supports any DEPTH >= 2, including depths that are not
//   powers of two.
//
//   There are two read modes:
//     - First-word-fall-through (FWFT_MODE == "TRUE"). The head word is shown
//       on o_rd_data while the FIFO is not empty, without a read request.
//     - Standard mode. A read registers the head word into o_rd_data, and
//       o_valid pulses high for one cycle.
//
//   Every status flag is registered. Each flag is computed from the next-state
//   count, so it is correct in the cycle after the clock edge.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          asynchronous reset, active-high
//   i_flush      synchronous clear of pointers and count; takes priority over
//                i_wr and i_rd
//   i_wr         write request;  i_wr_data  write data
//   i_rd         read request
//   i_clr_err    clears the sticky o_overflow and o_underflow flags
//   o_rd_data    read data;  o_valid  o_rd_data holds a valid word
//   o_empty      count == 0
//   o_full       count == DEPTH
//   o_aempty     count <= AE_LEVEL
//   o_afull      count >= AF_LEVEL
//   o_count      number of entries currently stored
//   o_overflow   sticky flag: a write was attempted while full
//   o_underflow  sticky flag: a read was attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_reg_ext #(
    parameter string FWFT_MODE  = "TRUE",
    parameter int    DEPTH      = 8,
    parameter int    DATA_WIDTH = 16,
    parameter int    AF_LEVEL   = 6,
    parameter int    AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_wr,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_rd,
    input  logic                          i_clr_err,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_valid,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_aempty,
    output logic                          o_afull,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam bit FWFT  = (FWFT_MODE == "TRUE");

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage array. It has no reset because its contents after reset do not
    // matter.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0]      r_ptr_q, r_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  valid_q, valid_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_en;
    logic                  rd_en;

    always_comb begin
        // A write to a full FIFO is refused even when a read is accepted in
        // the same cycle. A read from an empty FIFO is refused even when a
        // write is accepted in the same cycle.
        wr_acc = i_wr & ~full_q;
        rd_acc = i_rd & ~empty_q;
        // Flush cancels both accepted operations.
        wr_en  = wr_acc & ~i_flush;
        rd_en  = rd_acc & ~i_flush;

        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        valid_d   = 1'b0;

        if (i_flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            // Wrap explicitly so that depths which are not a power of two work.
            if (wr_en) begin
                w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                r_ptr_d   = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PTR_W'(1);
                rd_data_d = mem_q[r_ptr_q];
                valid_d   = 1'b1;
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == FULL_CNT);
        aempty_d = (count_d <= AE_CNT);
        afull_d  = (count_d >= AF_CNT);

        // A new error takes priority over a clear in the same cycle.
        // Flush does not change the error flags.
        overflow_d  = (i_wr & full_q)  ? 1'b1 : (i_clr_err ? 1'b0 : overflow_q);
        underflow_d = (i_rd & empty_q) ? 1'b1 : (i_clr_err ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            aempty_q    <= aempty_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_ptr_q] <= i_wr_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && i_wr && full_q) begin
            $warning("sync_fifo_reg_ext: write while full, word dropped");
        end
        if (!rst && i_rd && empty_q) begin
            $warning("sync_fifo_reg_ext: read while empty, request ignored");
        end
    end
`endif

    // In FWFT mode, an empty FIFO drives zeros rather than stale storage.
    // This also makes the output read as zero straight after reset.
    assign o_rd_data   = FWFT ? (empty_q ? '0 : mem_q[r_ptr_q]) : rd_data_q;
    assign o_valid     = FWFT ? ~empty_q : valid_q;
    assign o_empty     = empty_q;
    assign o_full      = full_q;
    assign o_aempty    = aempty_q;
    assign o_afull     = afull_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_reg_ext.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_reg_ext
//   Drives an FWFT instance and a standard-mode instance of the FIFO from the
//   same inputs. Both instances have DEPTH=5, AF_LEVEL=4 and AE_LEVEL=1.
//   Each output is compared with a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_sync_fifo_reg_ext;

    localparam int D  = 5;
    localparam int W  = 16;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(D + 1);
    localparam int OW = 7 + CW + W;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush, i_wr, i_rd, i_clr_err;
    logic [W-1:0]  i_wr_data;

    logic [W-1:0]  f_rd_data, s_rd_data;
    logic          f_valid, f_empty, f_full, f_aempty, f_afull, f_overflow, f_underflow;
    logic          s_valid, s_empty, s_full, s_aempty, s_afull, s_overflow, s_underflow;
    logic [CW-1:0] f_count, s_count;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_sv;
    logic [W-1:0] m_sd;

    always #5 clk = ~clk;

    sync_fifo_reg_ext #(.FWFT_MODE("TRUE"), .DEPTH(D), .DATA_WIDTH(W),
                        .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_f (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_wr(i_wr), .i_wr_data(i_wr_data),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_rd_data(f_rd_data), .o_valid(f_valid),
        .o_empty(f_empty), .o_full(f_full), .o_aempty(f_aempty), .o_afull(f_afull),
        .o_count(f_count), .o_overflow(f_overflow), .o_underflow(f_underflow));

    sync_fifo_reg_ext #(.FWFT_MODE("FALSE"), .DEPTH(D), .DATA_WIDTH(W),
                        .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_s (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_wr(i_wr), .i_wr_data(i_wr_data),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_rd_data(s_rd_data), .o_valid(s_valid),
        .o_empty(s_empty), .o_full(s_full), .o_aempty(s_aempty), .o_afull(s_afull),
        .o_count(s_count), .o_overflow(s_overflow), .o_underflow(s_underflow));

    wire [OW-1:0] obs_f = {f_empty, f_full, f_aempty, f_afull, f_count,
                           f_overflow, f_underflow, f_valid, f_rd_data};
    wire [OW-1:0] obs_s = {s_empty, s_full, s_aempty, s_afull, s_count,
                           s_overflow, s_underflow, s_valid, s_rd_data};

    // Expected packed outputs, computed from the occupancy of the model queue.
    function automatic logic [OW-1:0] exp_obs(input bit fwft);
        int           n;
        logic         v;
        logic [W-1:0] d;
        n = q.size();
        if (fwft) begin
            v = (n > 0);
            d = (n > 0) ? q[0] : '0;
        end else begin
            v = m_sv;
            d = m_sd;
        end
        return {(n == 0), (n == D), (n <= AE), (n >= AF), CW'(n), m_ovf, m_unf, v, d};
    endfunction

    function automatic logic [OW-1:0] reset_obs();
        return {1'b1, 1'b0, 1'b1, 1'b0, CW'(0), 1'b0, 1'b0, 1'b0, W'(0)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_sv  = 0;
        m_sd  = '0;
    endtask

    // Applies one clock cycle of stimulus and advances the model.
    task automatic cycle(input bit wr, input logic [W-1:0] d, input bit rd,
                         input bit fl, input bit clr);
        bit full_m, empty_m;
        i_wr = wr; i_wr_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
        @(posedge clk);
        full_m  = (q.size() == D);
        empty_m = (q.size() == 0);
        if (wr && full_m) m_ovf = 1; else if (clr) m_ovf = 0;
        if (rd && empty_m) m_unf = 1; else if (clr) m_unf = 0;
        m_sv = 0;
        if (fl) begin
            q.delete();
        end else begin
            if (rd && !empty_m) begin
                m_sd = q.pop_front();
                m_sv = 1;
            end
            if (wr && !full_m) q.push_back(d);
        end
        #1;
        $display("txn t=%0t wr=%0b data=%h rd=%0b flush=%0b clr=%0b -> count=%0d fwft_data=%h std_valid=%0b std_data=%h",
                 $time, wr, d, rd, fl, clr, f_count, f_rd_data, s_valid, s_rd_data);
        i_wr = 0; i_rd = 0; i_flush = 0; i_clr_err = 0;
    endtask

    task automatic test_reset();
        rst = 1; i_wr = 0; i_rd = 0; i_flush = 0; i_clr_err = 0; i_wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_f !== reset_obs()) begin
            errors++; $display("FAIL reset_fwft: got %h expected %h", obs_f, reset_obs());
        end
        checks++;
        if (obs_s !== reset_obs()) begin
            errors++; $display("FAIL reset_std: got %h expected %h", obs_s, reset_obs());
        end
        rst = 0;
        #2;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D; i++) begin
            cycle(1, W'(17 * (i + 1)), 0, 0, 0);
            checks++;
            if (obs_f !== exp_obs(1)) begin
                errors++; $display("FAIL fill_fwft[%0d]: got %h expected %h", i, obs_f, exp_obs(1));
            end
            checks++;
            if (obs_s !== exp_obs(0)) begin
                errors++; $display("FAIL fill_std[%0d]: got %h expected %h", i, obs_s, exp_obs(0));
            end
        end
        checks++;
        if ({f_full, f_afull, f_count} !== {1'b1, 1'b1, CW'(5)}) begin
            errors++; $display("FAIL full_flags: got full=%0b afull=%0b count=%0d expected 1 1 5",
                               f_full, f_afull, f_count);
        end
        cycle(1, 16'h0066, 0, 0, 0);
        checks++;
        if (f_overflow !== 1'b1 || s_overflow !== 1'b1 || f_count !== CW'(5)) begin
            errors++; $display("FAIL overflow_set: got ovf=%0b/%0b count=%0d expected 1/1 5",
                               f_overflow, s_overflow, f_count);
        end
    endtask

    task automatic test_drain_underflow();
        logic [W-1:0] want;
        for (int i = 0; i < D; i++) begin
            want = W'(17 * (i + 1));
            checks++;
            if (f_rd_data !== want) begin
                errors++; $display("FAIL drain_fwft_head[%0d]: got %h expected %h", i, f_rd_data, want);
            end
            cycle(0, '0, 1, 0, 0);
            checks++;
            if (s_rd_data !== want || s_valid !== 1'b1) begin
                errors++; $display("FAIL drain_std[%0d]: got %h/v%0b expected %h/v1", i, s_rd_data, s_valid, want);
            end
            checks++;
            if (obs_f !== exp_obs(1)) begin
                errors++; $display("FAIL drain_fwft_state[%0d]: got %h expected %h", i, obs_f, exp_obs(1));
            end
        end
        checks++;
        if (f_empty !== 1'b1 || f_underflow !== 1'b0) begin
            errors++; $display("FAIL drained_empty: got empty=%0b unf=%0b expected 1 0", f_empty, f_underflow);
        end
        cycle(0, '0, 1, 0, 0);
        checks++;
        if (f_underflow !== 1'b1 || s_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_set: got %0b/%0b expected 1/1", f_underflow, s_underflow);
        end
        cycle(0, '0, 0, 0, 1);
        checks++;
        if ({f_overflow, f_underflow, s_overflow, s_underflow} !== 4'b0000) begin
            errors++; $display("FAIL clr_err: got %b expected 0000",
                               {f_overflow, f_underflow, s_overflow, s_underflow});
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2; i++) cycle(1, W'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, W'($urandom), 1, 0, 0);
            checks++;
            if (obs_f !== exp_obs(1) || f_count !== CW'(2)) begin
                errors++; $display("FAIL simul_fwft[%0d]: got %h expected %h", i, obs_f, exp_obs(1));
            end
            checks++;
            if (obs_s !== exp_obs(0)) begin
                errors++; $display("FAIL simul_std[%0d]: got %h expected %h", i, obs_s, exp_obs(0));
            end
        end
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(1, 16'h0BEE, 1, 0, 0);
        checks++;
        if (f_count !== CW'(1) || obs_f !== exp_obs(1)) begin
            errors++; $display("FAIL simul_at_empty: got count=%0d obs=%h expected 1 %h", f_count, obs_f, exp_obs(1));
        end
        for (int i = 0; i < D - 1; i++) cycle(1, W'($urandom), 0, 0, 0);
        cycle(1, 16'h0FAD, 1, 0, 0);
        checks++;
        if (s_count !== CW'(D - 1) || obs_s !== exp_obs(0)) begin
            errors++; $display("FAIL simul_at_full: got count=%0d obs=%h expected %0d %h", s_count, obs_s, D - 1, exp_obs(0));
        end
    endtask

    task automatic test_fwft_vs_std();
        cycle(0, '0, 0, 1, 0);
        cycle(1, 16'hA5A5, 0, 0, 0);
        checks++;
        if (f_valid !== 1'b1 || f_rd_data !== 16'hA5A5) begin
            errors++; $display("FAIL fwft_fallthrough: got v%0b %h expected v1 a5a5", f_valid, f_rd_data);
        end
        cycle(0, '0, 0, 0, 0);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL std_no_read_valid: got %0b expected 0", s_valid);
        end
        cycle(0, '0, 1, 0, 0);
        checks++;
        if (s_valid !== 1'b1 || s_rd_data !== 16'hA5A5) begin
            errors++; $display("FAIL std_read: got v%0b %h expected v1 a5a5", s_valid, s_rd_data);
        end
        cycle(0, '0, 0, 0, 0);
        checks++;
        if (s_valid !== 1'b0 || s_rd_data !== 16'hA5A5 || f_valid !== 1'b0) begin
            errors++; $display("FAIL std_pulse: got v%0b %h fv%0b expected v0 a5a5 fv0", s_valid, s_rd_data, f_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, W'($urandom), 0, 0, 0);
        cycle(1, 16'h7777, 0, 1, 0);
        checks++;
        if (f_count !== CW'(0) || f_empty !== 1'b1 || f_overflow !== 1'b1 || s_overflow !== 1'b1) begin
            errors++; $display("FAIL flush: got count=%0d empty=%0b ovf=%0b/%0b expected 0 1 1/1",
                               f_count, f_empty, f_overflow, s_overflow);
        end
        cycle(0, '0, 0, 0, 0);
        checks++;
        if (obs_f !== exp_obs(1) || obs_s !== exp_obs(0)) begin
            errors++; $display("FAIL flush_discard: got %h/%h expected %h/%h", obs_f, obs_s, exp_obs(1), exp_obs(0));
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(1, W'($urandom), 0, 0, 0);
        i_wr = 1; i_wr_data = 16'h1234;
        rst = 1;
        #2;
        model_reset();
        checks++;
        if (obs_f !== reset_obs() || obs_s !== reset_obs()) begin
            errors++; $display("FAIL async_reset: got %h/%h expected %h", obs_f, obs_s, reset_obs());
        end
        i_wr = 0;
        @(posedge clk);
        #3;
        rst = 0;
        cycle(1, 16'h4321, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        checks++;
        if (obs_f !== exp_obs(1) || s_rd_data !== 16'h4321) begin
            errors++; $display("FAIL after_reset: got %h std=%h expected %h std=4321", obs_f, s_rd_data, exp_obs(1));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
            checks++;
            if (obs_f !== exp_obs(1)) begin
                errors++; $display("FAIL random_fwft[%0d]: got %h expected %h", i, obs_f, exp_obs(1));
            end
            checks++;
            if (obs_s !== exp_obs(0)) begin
                errors++; $display("FAIL random_std[%0d]: got %h expected %h", i, obs_s, exp_obs(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_fwft_vs_std();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
